// File: rtl/mbus_read_requester_if.sv
// Bus bundle for the MBUS read requester.
//   master : the requester's view. It takes read requests, drives START/ADR/RQ
//            toward memory, receives ACKN/VALID/data/parity and presents
//            returned words plus error pulses to the cache-fill consumer.
//   slave  : the opposite view, used by whatever sits around the requester
//            (request source, memory phase, consumer).
// Signals:
//   reqValid/reqReady/reqAddr/reqRq     read request handshake
//   start/adr/rq                        MBUS request phase
//   ackn/inValid/dIn/parIn              memory return phase
//   wordValid/wordReady/wordData/wordAddr  returned-word stream
//   badRq/timeoutErr/parErr             status
interface mbus_read_requester_if;
  logic          reqValid;
  logic          reqReady;
  logic [14:35]  reqAddr;
  logic [0:3]    reqRq;
  logic          start;
  logic [14:35]  adr;
  logic [0:3]    rq;
  logic          ackn;
  logic          inValid;
  logic [35:0]   dIn;
  logic          parIn;
  logic          wordValid;
  logic          wordReady;
  logic [35:0]   wordData;
  logic [14:35]  wordAddr;
  logic          badRq;
  logic          timeoutErr;
  logic          parErr;

  modport master (
    input  reqValid, reqAddr, reqRq, ackn, inValid, dIn, parIn, wordReady,
    output reqReady, start, adr, rq, wordValid, wordData, wordAddr,
           badRq, timeoutErr, parErr
  );

  modport slave (
    output reqValid, reqAddr, reqRq, ackn, inValid, dIn, parIn, wordReady,
    input  reqReady, start, adr, rq, wordValid, wordData, wordAddr,
           badRq, timeoutErr, parErr
  );
endinterface

// File: rtl/mbus_read_requester.sv
// MBOX-side MBUS read requester.
// Accepts one read request at a time and issues it as a quadword MBUS cycle
// (START held until the first ACKN, ADR/RQ held for the whole cycle). Every
// ACKN with VALID returns one word, which is buffered together with its word
// address and drained to the cache-fill consumer over a valid/ready port.
//
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous, active-high
//   bus    mbus_read_requester_if.master (request, MBUS, word stream, status)
//
// Parameters:
//   FIFO_DEPTH    returned-word buffer entries (power of 2, >= 4)
//   ACKN_TIMEOUT  cycles of START without ACKN before the cycle is aborted
//
// Build option:
//   MBUS_PARITY_CHECK_EN  when defined, every returned word is checked for
//                         even parity and parErr latches a mismatch until the
//                         next accepted request. When undefined parErr is 0
//                         and parIn is ignored.
module mbus_read_requester #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ACKN_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  mbus_read_requester_if.master bus
);

  localparam int DATA_W = 36;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMO_W  = (ACKN_TIMEOUT > 2) ? $clog2(ACKN_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACKN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  // Word count of a request mask; 0 marks an illegal mask. Only a
  // left-justified run of ones is a legal quadword request.
  function automatic logic [2:0] rq_words(input logic [0:3] r);
    case (r)
      4'b1000: rq_words = 3'd1;
      4'b1100: rq_words = 3'd2;
      4'b1110: rq_words = 3'd3;
      4'b1111: rq_words = 3'd4;
      default: rq_words = 3'd0;
    endcase
  endfunction

  // Even parity: a good word has parity bit equal to the XOR of its data.
  function automatic logic par_bad(input logic [DATA_W-1:0] d, input logic p);
    par_bad = (p != ^d);
  endfunction

  state_t           state;
  logic             start_q;
  logic [14:35]     adr_q;
  logic [0:3]       rq_q;
  logic [1:0]       wo_q;
  logic [2:0]       remain_q;
  logic [TMO_W-1:0] tmo_q;
  logic             bad_rq_q;
  logic             tmo_err_q;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [21:0]       mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic [2:0]       n_req;
  logic             rq_legal;
  logic [CNT_W-1:0] fifo_free;
  logic             req_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic             last_word;

  assign n_req     = rq_words(bus.reqRq);
  assign rq_legal  = (n_req != 3'd0);
  assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_cnt;
  // Illegal masks are always consumed in IDLE so they can be reported.
  assign req_ready = (state == IDLE) &&
                     (!rq_legal || (fifo_free >= CNT_W'(n_req)));
  assign accept    = bus.reqValid && req_ready;
  // Only ACKN carrying data moves a word; stray ACKN in IDLE is ignored.
  assign push      = (state != IDLE) && bus.ackn && bus.inValid;
  assign pop       = (fifo_cnt != '0) && bus.wordReady;
  assign last_word = (remain_q == 3'd1);

  // Request / MBUS cycle control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      adr_q     <= '0;
      rq_q      <= '0;
      wo_q      <= '0;
      remain_q  <= '0;
      tmo_q     <= '0;
      bad_rq_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      bad_rq_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (rq_legal) begin
              adr_q    <= bus.reqAddr;
              rq_q     <= bus.reqRq;
              wo_q     <= bus.reqAddr[34:35];
              remain_q <= n_req;
              tmo_q    <= '0;
              start_q  <= 1'b1;
              state    <= START;
            end else begin
              bad_rq_q <= 1'b1;
            end
          end
        end
        START: begin
          if (bus.ackn) begin
            // First ACKN ends the START phase; with data it is also word 0.
            start_q <= 1'b0;
            state   <= XFER;
            if (bus.inValid) begin
              wo_q     <= wo_q + 2'd1;
              remain_q <= remain_q - 3'd1;
              if (last_word) state <= IDLE;
            end
          end else if (tmo_q == TMO_LAST) begin
            start_q   <= 1'b0;
            tmo_err_q <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        XFER: begin
          if (bus.ackn && bus.inValid) begin
            // Word offset wraps inside the quadword.
            wo_q     <= wo_q + 2'd1;
            remain_q <= remain_q - 3'd1;
            if (last_word) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned-word buffer: control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Returned-word buffer: storage (contents are don't-care until counted)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.dIn;
      mem_addr[wr_ptr] <= {adr_q[14:33], wo_q};
    end
  end

`ifdef MBUS_PARITY_CHECK_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= 1'b0;
    end else if (push && par_bad(bus.dIn, bus.parIn)) begin
      par_err_q <= 1'b1;
    end
  end

  assign bus.parErr = par_err_q;
`else
  assign bus.parErr = 1'b0;
`endif

  assign bus.reqReady   = req_ready;
  assign bus.start      = start_q;
  assign bus.adr        = adr_q;
  assign bus.rq         = rq_q;
  assign bus.wordValid  = (fifo_cnt != '0);
  assign bus.wordData   = mem_data[rd_ptr];
  assign bus.wordAddr   = mem_addr[rd_ptr];
  assign bus.badRq      = bad_rq_q;
  assign bus.timeoutErr = tmo_err_q;

endmodule

// File: tb/tb_mbus_read_requester.sv
module tb_mbus_read_requester;
  localparam int FIFO_DEPTH   = 8;
  localparam int ACKN_TIMEOUT = 64;
`ifdef MBUS_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mbus_read_requester_if bus_if();

  mbus_read_requester #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACKN_TIMEOUT(ACKN_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] data;
    logic [21:0] addr;
  } word_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q[$];
  int    rdy_mode = 2;   // 0 random, 1 always ready, 2 stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rules: legal mask is a left-justified run of n ones.
  function automatic int n_words(input logic [3:0] r);
    logic [3:0] pat;
    for (int n = 1; n <= 4; n++) begin
      pat = 4'((8'h0F << (4 - n)) & 8'h0F);
      if (r == pat) return n;
    end
    return 0;
  endfunction

  // Word k of a request: same quadword, offset advances mod 4.
  function automatic logic [21:0] word_addr(input logic [21:0] base, input int k);
    return (base & ~22'd3) | ((base + 22'(k)) & 22'd3);
  endfunction

  // Consumer
  initial begin
    bus_if.wordReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus_if.wordReady = 1'($urandom_range(0, 1));
        1:       bus_if.wordReady = 1'b1;
        default: bus_if.wordReady = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  logic        held;
  logic [35:0] held_d;
  logic [21:0] held_a;
  word_t       got_w;
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", bus_if.wordValid, 1'b1);
          check("hold_word", {bus_if.wordData, bus_if.wordAddr}, {held_d, held_a});
        end
        if (bus_if.wordValid && bus_if.wordReady) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", bus_if.wordValid, 1'b0);
          end else begin
            got_w = exp_q.pop_front();
            check("word_data", bus_if.wordData, got_w.data);
            check("word_addr", bus_if.wordAddr, got_w.addr);
          end
        end
        held   = bus_if.wordValid && !bus_if.wordReady;
        held_d = bus_if.wordData;
        held_a = bus_if.wordAddr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_req(input logic [21:0] a, input logic [3:0] r, output int waitc);
    waitc = 0;
    @(posedge clk); #1;
    bus_if.reqValid = 1'b1;
    bus_if.reqAddr  = a;
    bus_if.reqRq    = r;
    @(negedge clk);
    while (!bus_if.reqReady && waitc < 400) begin
      @(negedge clk);
      waitc++;
    end
    check("req_ready_bound", bus_if.reqReady, 1'b1);
    @(posedge clk); #1;
    bus_if.reqValid = 1'b0;
  endtask

  task automatic run_txn(input logic [21:0] a, input logic [3:0] r, input bit tmo,
                         input bit badpar, input bit chk_lat, input bit rnd,
                         input bit fixd, input logic [35:0] fdata);
    int          n, waitc, k, pre, cnt;
    bit          just0, latp;
    logic [35:0] d [4];
    word_t       w;
    n = n_words(r);
    send_req(a, r, waitc);
    if (n == 0) begin
      @(negedge clk);
      check("badrq_pulse", bus_if.badRq, 1'b1);
      check("badrq_no_start", bus_if.start, 1'b0);
      @(negedge clk);
      check("badrq_once", bus_if.badRq, 1'b0);
      check("badrq_no_start2", bus_if.start, 1'b0);
      return;
    end
    if (!tmo) begin
      for (int i = 0; i < n; i++) begin
        d[i]   = fixd ? fdata : {4'($urandom), 32'($urandom)};
        w.data = d[i];
        w.addr = word_addr(a, i);
        exp_q.push_back(w);
      end
    end
    @(negedge clk);
    check("start_after_accept", bus_if.start, 1'b1);
    check("adr", bus_if.adr, a);
    check("rq", bus_if.rq, r);
    check("busy_not_ready", bus_if.reqReady, 1'b0);
    check("parerr_clear_on_accept", bus_if.parErr, 1'b0);
    if (tmo) begin
      cnt = 0;
      for (int i = 0; i < ACKN_TIMEOUT + 10; i++) begin
        if (!bus_if.start) break;
        cnt++;
        @(negedge clk);
      end
      check("tmo_start_cycles", cnt, ACKN_TIMEOUT);
      check("tmo_err_pulse", bus_if.timeoutErr, 1'b1);
      @(negedge clk);
      check("tmo_err_once", bus_if.timeoutErr, 1'b0);
      return;
    end
    pre  = rnd ? $urandom_range(0, 4) : 1;
    k    = 0;
    latp = 1'b0;
    while (k < n) begin
      @(posedge clk); #1;
      bus_if.ackn    = 1'b0;
      bus_if.inValid = 1'b0;
      just0          = 1'b0;
      if (k == 0 && pre > 0) begin
        pre--;
      end else if (k > 0 && rnd && $urandom_range(0, 2) == 0) begin
        bus_if.ackn = 1'($urandom_range(0, 1));   // ACKN without data: no word
      end else begin
        bus_if.ackn    = 1'b1;
        bus_if.inValid = 1'b1;
        bus_if.dIn     = d[k];
        bus_if.parIn   = (^d[k]) ^ badpar;
        just0          = (k == 0);
        k++;
      end
      @(negedge clk);
      check("start_until_ackn", bus_if.start, (k == 0) || just0);
      if (latp) begin
        check("first_word_latency", bus_if.wordValid, 1'b1);
        latp = 1'b0;
      end
      if (just0 && chk_lat) latp = 1'b1;
    end
    @(posedge clk); #1;
    bus_if.ackn    = 1'b0;
    bus_if.inValid = 1'b0;
    @(negedge clk);
    check("start_low_after", bus_if.start, 1'b0);
    if (latp) check("first_word_latency", bus_if.wordValid, 1'b1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || bus_if.wordValid) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("drain_valid", bus_if.wordValid, 1'b0);
    check("drain_left", exp_q.size(), 0);
  endtask

  int       waitc;
  bit       tm;
  logic [3:0] r;
  initial begin
    reset            = 1'b1;
    bus_if.reqValid  = 1'b0;
    bus_if.reqAddr   = '0;
    bus_if.reqRq     = 4'b1111;
    bus_if.ackn      = 1'b0;
    bus_if.inValid   = 1'b0;
    bus_if.dIn       = '0;
    bus_if.parIn     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", bus_if.start, 1'b0);
    check("rst_adr", bus_if.adr, 22'd0);
    check("rst_rq", bus_if.rq, 4'd0);
    check("rst_wordvalid", bus_if.wordValid, 1'b0);
    check("rst_badrq", bus_if.badRq, 1'b0);
    check("rst_tmoerr", bus_if.timeoutErr, 1'b0);
    check("rst_parerr", bus_if.parErr, 1'b0);
    check("rst_reqready", bus_if.reqReady, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Quad read with first-word latency, then drain
    rdy_mode = 2;
    run_txn(22'o0100, 4'b1111, 0, 0, 1, 0, 0, '0);
    rdy_mode = 1;
    wait_drain();

    // Wrap inside the quadword
    run_txn(22'o0102, 4'b1111, 0, 0, 0, 0, 0, '0);
    wait_drain();

    // Backpressure
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    run_txn(22'o0200, 4'b1111, 0, 0, 0, 1, 0, '0);
    send_req(22'o0204, 4'b1111, waitc);
    check("bp_second_accept_wait", waitc, 0);
    exp_q.push_back('{data: 36'h0, addr: 22'h0});
    void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus_if.ackn = 1'b1; bus_if.inValid = 1'b1;
      bus_if.dIn = 36'(i + 100); bus_if.parIn = ^(36'(i + 100));
      exp_q.push_back('{data: 36'(i + 100), addr: word_addr(22'o0204, i)});
    end
    @(posedge clk); #1;
    bus_if.ackn = 1'b0; bus_if.inValid = 1'b0;
    bus_if.reqValid = 1'b1; bus_if.reqAddr = 22'o0300; bus_if.reqRq = 4'b1000;
    repeat (4) begin
      @(negedge clk);
      check("bp_full_not_ready", bus_if.reqReady, 1'b0);
    end
    bus_if.reqValid = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_pop", bus_if.reqReady, 1'b1);
    wait_drain();

    // Illegal mask
    run_txn(22'o0400, 4'b0101, 0, 0, 0, 0, 0, '0);
    repeat (3) @(negedge clk);
    check("illegal_no_start", bus_if.start, 1'b0);
    check("illegal_fifo_empty", bus_if.wordValid, 1'b0);

    // Timeout
    run_txn(22'o0500, 4'b1111, 1, 0, 0, 0, 0, '0);
    check("tmo_ready_again", bus_if.reqReady, 1'b1);
    check("tmo_no_words", bus_if.wordValid, 1'b0);

    // Parity
    run_txn(22'o0600, 4'b1000, 0, 1, 0, 0, 1, 36'o1);
    check("par_err_set", bus_if.parErr, PAR_EN);
    wait_drain();
    run_txn(22'o0610, 4'b1000, 0, 0, 0, 0, 0, '0);
    wait_drain();

    // Randomized traffic
    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      r  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(8'hF0 >> $urandom_range(1, 4));
      tm = (n_words(r) != 0) && ($urandom_range(0, 9) == 0);
      run_txn(22'($urandom), r, tm, 0, 0, 1, 0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        bus_if.ackn = 1'b1; bus_if.inValid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus_if.ackn = 1'b0; bus_if.inValid = 1'b0;
      end
    end
    rdy_mode = 1;
    wait_drain();

    // Reset in the middle of a cycle
    rdy_mode = 2;
    send_req(22'o0700, 4'b1111, waitc);
    @(posedge clk); #1;
    bus_if.ackn = 1'b1; bus_if.inValid = 1'b1; bus_if.dIn = 36'o7; bus_if.parIn = 1'b1;
    @(posedge clk); #1;
    bus_if.ackn = 1'b0; bus_if.inValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_start", bus_if.start, 1'b0);
    check("midrst_fifo", bus_if.wordValid, 1'b0);
    check("midrst_ready", bus_if.reqReady, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("after_rst_fifo", bus_if.wordValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
